// File: rtl/op_load_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : op_load_arbiter
// Purpose  : Round-robin arbiter that lets N_REQ requesters take turns
//            loading a 5-bit op code into a shared operation register.
//            After each load, the arbiter locks out all requesters for
//            HOLD_CYCLES cycles. A clear request overrides any grant in
//            progress and asserts the register's synchronous clear.
// Ports    : clk       - rising-edge clock
//            rst       - asynchronous reset, active low
//            req       - one load-request bit per requester
//            req_data  - 5-bit op code per requester, packed
//                        (requester i uses bits [5i+4:5i])
//            clr_req   - request to clear the operation register
//            ack       - one-cycle, one-hot acknowledge to the loaded requester
//            reg_en    - operation register load enable
//            reg_d     - operation register data input (last latched code)
//            reg_clr   - operation register synchronous clear
//            grant_id  - index of the current or most recent grant
//            busy      - high whenever the arbiter is not idle
// Revision : 1.0 - initial release
// ============================================================================
module op_load_arbiter #(
  parameter int N_REQ       = 4,
  parameter int HOLD_CYCLES = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*5-1:0] req_data,
  input  logic               clr_req,
  output logic [N_REQ-1:0]   ack,
  output logic               reg_en,
  output logic [4:0]         reg_d,
  output logic               reg_clr,
  output logic [2:0]         grant_id,
  output logic               busy
);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_grant = 2'd1;
  localparam logic [1:0] c_st_hold  = 2'd2;

  // The counter is loaded with HOLD_CYCLES-1 and HOLD exits on zero, so the
  // FSM spends exactly HOLD_CYCLES cycles in HOLD.
  localparam logic [7:0] c_hold_load = (HOLD_CYCLES > 0) ? 8'(HOLD_CYCLES - 1) : 8'd0;
  localparam logic       c_use_hold  = (HOLD_CYCLES > 0);
  localparam logic [2:0] c_last_id   = 3'(N_REQ - 1);

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic [2:0] r_rr_ptr;
  logic [2:0] r_grant_id;
  logic [4:0] r_data;
  logic [7:0] r_hold_cnt;
  logic       r_clr;

  logic       w_any;
  logic [2:0] w_win_id;
  logic [4:0] w_win_data;
  logic [2:0] w_ptr_nxt;
  logic       w_grant_live;

  // --------------------------------------------------------------------------
  // Round-robin winner: the set request with the smallest upward distance
  // from r_rr_ptr (with wrap-around) wins.
  // --------------------------------------------------------------------------
  always_comb begin
    int w_best;
    int w_dist;
    int w_ptr;
    w_any      = 1'b0;
    w_win_id   = 3'd0;
    w_win_data = 5'd0;
    w_best     = N_REQ;
    w_dist     = 0;
    w_ptr      = int'(r_rr_ptr);
    for (int i = 0; i < N_REQ; i++) begin
      w_dist = (i >= w_ptr) ? (i - w_ptr) : (i + N_REQ - w_ptr);
      if (req[i] && (w_dist < w_best)) begin
        w_best     = w_dist;
        w_any      = 1'b1;
        w_win_id   = 3'(i);
        w_win_data = req_data[5*i +: 5];
      end
    end
  end

  assign w_ptr_nxt = (r_grant_id == c_last_id) ? 3'd0 : (r_grant_id + 3'd1);

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state logic; a clear request forces IDLE from every state and
  // beats a simultaneous selection.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: begin
        if (clr_req) begin
          w_state_nxt = c_st_idle;
        end else if (w_any) begin
          w_state_nxt = c_st_grant;
        end
      end
      c_st_grant: begin
        if (clr_req || !c_use_hold) begin
          w_state_nxt = c_st_idle;
        end else begin
          w_state_nxt = c_st_hold;
        end
      end
      c_st_hold: begin
        if (clr_req || (r_hold_cnt == 8'd0)) begin
          w_state_nxt = c_st_idle;
        end
      end
      default: w_state_nxt = c_st_idle;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers: grant latch, round-robin pointer, hold counter and
  // the one-cycle-delayed clear.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_ptr   <= 3'd0;
      r_grant_id <= 3'd0;
      r_data     <= 5'd0;
      r_hold_cnt <= 8'd0;
      r_clr      <= 1'b0;
    end else begin
      r_clr <= clr_req;
      case (r_state)
        c_st_idle: begin
          if (!clr_req && w_any) begin
            r_grant_id <= w_win_id;
            r_data     <= w_win_data;
          end
        end
        c_st_grant: begin
          // An aborted grant leaves the pointer where it was.
          if (!clr_req) begin
            r_rr_ptr   <= w_ptr_nxt;
            r_hold_cnt <= c_hold_load;
          end
        end
        c_st_hold: begin
          if (clr_req) begin
            r_hold_cnt <= 8'd0;
          end else if (r_hold_cnt != 8'd0) begin
            r_hold_cnt <= r_hold_cnt - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // FSM outputs. A clear arriving during GRANT suppresses the load in that
  // same cycle, so reg_en and reg_clr can never overlap.
  // --------------------------------------------------------------------------
  always_comb begin
    w_grant_live = (r_state == c_st_grant) && !clr_req;
    reg_en       = w_grant_live;
    ack          = '0;
    for (int i = 0; i < N_REQ; i++) begin
      ack[i] = w_grant_live && (r_grant_id == 3'(i));
    end
    reg_d    = r_data;
    reg_clr  = r_clr;
    grant_id = r_grant_id;
    busy     = (r_state != c_st_idle);
  end

endmodule
`default_nettype wire

// File: tb/tb_op_load_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_op_load_arbiter
// Purpose  : Self-checking bench for op_load_arbiter. Two instances share
//            one stimulus stream: HOLD_CYCLES=8 and HOLD_CYCLES=0. Each is
//            compared every cycle against a cycle-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_op_load_arbiter;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = '0;
  logic [19:0] req_data = '0;
  logic        clr_req = 1'b0;

  logic [3:0] ack0, ack1;
  logic       reg_en0, reg_en1;
  logic [4:0] reg_d0, reg_d1;
  logic       reg_clr0, reg_clr1;
  logic [2:0] gid0, gid1;
  logic       busy0, busy1;

  always #5 clk = ~clk;

  op_load_arbiter #(.N_REQ(N), .HOLD_CYCLES(8)) u_dut0 (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .clr_req(clr_req),
    .ack(ack0), .reg_en(reg_en0), .reg_d(reg_d0), .reg_clr(reg_clr0),
    .grant_id(gid0), .busy(busy0)
  );

  op_load_arbiter #(.N_REQ(N), .HOLD_CYCLES(0)) u_dut1 (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .clr_req(clr_req),
    .ack(ack1), .reg_en(reg_en1), .reg_d(reg_d1), .reg_clr(reg_clr1),
    .grant_id(gid1), .busy(busy1)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: a pending grant, remaining lockout cycles, pointer,
  // last grant and latched data, and whether a clear is being signalled.
  int m_pend[2];
  int m_lock[2];
  int m_ptr[2];
  int m_gid[2];
  int m_data[2];
  int m_clr[2];

  int en_t0[$];
  int en_g0[$];
  int en_t1[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pend[k] = 0; m_lock[k] = 0; m_ptr[k] = 0;
      m_gid[k]  = 0; m_data[k] = 0; m_clr[k] = 0;
    end
  endtask

  // Advance the model by one rising edge using the inputs held before it.
  task automatic model_edge();
    int w;
    int j;
    for (int k = 0; k < 2; k++) begin
      if (clr_req) begin
        m_pend[k] = 0;
        m_lock[k] = 0;
        m_clr[k]  = 1;
      end else begin
        m_clr[k] = 0;
        if (m_pend[k] != 0) begin
          m_pend[k] = 0;
          m_ptr[k]  = (m_gid[k] + 1) % N;
          m_lock[k] = (k == 0) ? 8 : 0;
        end else if (m_lock[k] > 0) begin
          m_lock[k] = m_lock[k] - 1;
        end else if (req != 4'd0) begin
          w = 0;
          for (int d = N - 1; d >= 0; d--) begin
            j = (m_ptr[k] + d) % N;
            if (req[j]) w = j;
          end
          m_gid[k]  = w;
          m_data[k] = int'((req_data >> (5 * w)) & 20'h1f);
          m_pend[k] = 1;
        end
      end
    end
  endtask

  task automatic compare_one(input string u, input int k, input logic en, input logic [3:0] ak,
                             input logic [4:0] d, input logic cl, input logic [2:0] g, input logic b);
    logic       en_e;
    logic [3:0] ack_e;
    en_e  = (m_pend[k] != 0) && !clr_req;
    ack_e = en_e ? (4'b0001 << m_gid[k]) : 4'b0000;
    check($sformatf("%s.reg_en", u),   32'(en),  32'(en_e));
    check($sformatf("%s.ack", u),      32'(ak),  32'(ack_e));
    check($sformatf("%s.reg_d", u),    32'(d),   32'(m_data[k]));
    check($sformatf("%s.reg_clr", u),  32'(cl),  32'(m_clr[k]));
    check($sformatf("%s.grant_id", u), 32'(g),   32'(m_gid[k]));
    check($sformatf("%s.busy", u),     32'(b),   32'((m_pend[k] != 0) || (m_lock[k] > 0)));
  endtask

  task automatic compare();
    compare_one("u0", 0, reg_en0, ack0, reg_d0, reg_clr0, gid0, busy0);
    compare_one("u1", 1, reg_en1, ack1, reg_d1, reg_clr1, gid1, busy1);
  endtask

  // One clock: model the edge, drive the next inputs, then check mid-cycle.
  task automatic cycle(input logic [3:0] r, input logic [19:0] d, input logic c);
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    req      = r;
    req_data = d;
    clr_req  = c;
    #3;
    compare();
    if (reg_en0) begin
      en_t0.push_back(cyc);
      en_g0.push_back(int'(gid0));
    end
    if (reg_en1) en_t1.push_back(cyc);
  endtask

  // Assert reset in the middle of a cycle and check outputs before the edge.
  task automatic async_reset();
    rst      = 1'b0;
    req      = '0;
    clr_req  = 1'b0;
    model_reset();
    #2;
    compare();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    model_reset();
    #12;
    compare();
    @(negedge clk);
    rst = 1'b1;

    // Round robin with all requests held.
    en_t0.delete(); en_g0.delete(); en_t1.delete();
    for (int i = 0; i < 44; i++) cycle(4'b1111, 20'h8c4a2, 1'b0);
    check("rr0.count", 32'(en_t0.size()), 32'd5);
    for (int i = 0; i < en_g0.size() && i < 5; i++)
      check($sformatf("rr0.order%0d", i), 32'(en_g0[i]), 32'(i % 4));
    for (int i = 1; i < en_t0.size() && i < 5; i++)
      check($sformatf("rr0.gap%0d", i), 32'(en_t0[i] - en_t0[i-1]), 32'd10);
    check("rr1.count", 32'(en_t1.size()), 32'd22);
    for (int i = 1; i < en_t1.size() && i < 4; i++)
      check($sformatf("rr1.gap%0d", i), 32'(en_t1[i] - en_t1[i-1]), 32'd2);

    // Reset while instance 0 sits in HOLD.
    check("u0.busy_pre_reset", 32'(busy0), 32'd1);
    async_reset();

    // Single request with code 5'h15.
    cycle(4'b0001, 20'h00015, 1'b0);
    for (int i = 0; i < 10; i++) cycle(4'b0000, 20'h00000, 1'b0);

    // Move pointer to 3, then wrap: req=0101 grants 0 then 2.
    cycle(4'b0100, 20'h0a000, 1'b0);
    for (int i = 0; i < 10; i++) cycle(4'b0000, 20'h00000, 1'b0);
    for (int i = 0; i < 12; i++) cycle(4'b0101, 20'h0b00e, 1'b0);
    for (int i = 0; i < 10; i++) cycle(4'b0000, 20'h00000, 1'b0);

    // Clear collides with a new selection; held request is granted after.
    cycle(4'b0010, 20'h00120, 1'b1);
    for (int i = 0; i < 12; i++) cycle(4'b0010, 20'h00120, 1'b0);

    // Clear during GRANT aborts the load and keeps the pointer.
    cycle(4'b0001, 20'h00007, 1'b0);
    cycle(4'b0000, 20'h00007, 1'b1);
    cycle(4'b0000, 20'h00000, 1'b0);
    for (int i = 0; i < 12; i++) cycle(4'b0011, 20'h00063, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic [3:0] r;
      r = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      cycle(r, 20'($urandom), ($urandom_range(0, 19) == 0));
      if (i == 300) async_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/op_load_arbiter.md
OP_LOAD_ARBITER -- requirements
Module: op_load_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, SHALL set the number of requesters sharing the operation register (2..8).
REQ-002 Parameter HOLD_CYCLES, default 8, SHALL set the lockout cycles after each load (0..255).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous active-low reset.
REQ-005 req  input  N_REQ  SHALL carry one load-request bit per requester.
REQ-006 req_data  input  N_REQ*5  SHALL carry each requester's 5-bit op code; requester i uses bits [5i+4:5i].
REQ-007 clr_req  input  1  SHALL request a clear of the operation register.
REQ-008 ack  output  N_REQ  SHALL pulse one-hot for one cycle to the requester whose code is loaded.
REQ-009 reg_en  output  1  SHALL drive the operation register's load enable.
REQ-010 reg_d  output  5  SHALL drive the operation register's data input.
REQ-011 reg_clr  output  1  SHALL drive the operation register's synchronous clear.
REQ-012 grant_id  output  3  SHALL give the index of the current or last granted requester.
REQ-013 busy  output  1  SHALL be high whenever the FSM is not in IDLE.

Function
REQ-014 FSM states SHALL be IDLE, GRANT and HOLD, encoded as registered state.
REQ-015 In IDLE with any req bit high, the winner SHALL be the first set bit at or after rr_ptr, searching upward with wrap-around from N_REQ-1 to 0.
REQ-016 On the selection edge, the winner index SHALL load into grant_id, its req_data slice SHALL load into a data register, and the FSM SHALL go to GRANT.
REQ-017 In GRANT, for exactly one cycle: reg_en=1, reg_d=latched data, ack[grant_id]=1, all other ack bits 0.
REQ-018 Latency: req sampled high in IDLE at edge t SHALL produce reg_en/ack during cycle t+1.
REQ-019 Leaving GRANT, rr_ptr SHALL become (grant_id+1) mod N_REQ.
REQ-020 Leaving GRANT, the FSM SHALL go to HOLD when HOLD_CYCLES>0, otherwise to IDLE.
REQ-021 HOLD SHALL last exactly HOLD_CYCLES cycles, tracked by an 8-bit down-counter, then return to IDLE; requests are ignored during HOLD.
REQ-022 Outside GRANT: reg_en=0, ack=0, and reg_d SHALL hold the last latched data.
REQ-023 A req bit dropped after selection SHALL NOT cancel the grant; the latched code is still loaded.
REQ-024 clr_req sampled high in any state SHALL cause reg_clr=1 for the next cycle and force IDLE; an in-progress GRANT is aborted (no reg_en, no ack) and rr_ptr is unchanged.
REQ-025 clr_req SHALL win over a simultaneous new selection in IDLE; no grant occurs on that edge.
REQ-026 reg_clr and reg_en SHALL never be high in the same cycle.
REQ-027 clr_req held high SHALL keep reg_clr high every cycle and the FSM in IDLE.

Reset
REQ-028 With rst low, outputs SHALL immediately become ack=0, reg_en=0, reg_clr=0, reg_d=0, grant_id=0, busy=0; internal state SHALL become IDLE, rr_ptr=0, counter=0.
REQ-029 Reset asserted mid-GRANT or mid-HOLD SHALL abandon the operation with no ack issued afterwards.
REQ-030 After rst rises, the first grant SHALL be possible on the first rising clock edge.

Verification
REQ-031 Single request: req=0001, data0=5'h15 -> cycle after: reg_en=1, reg_d=5'h15, ack=0001; busy high for 1+8 cycles.
REQ-032 Round robin: req=1111 held -> grants in order 0,1,2,3,0, consecutive reg_en pulses 10 cycles apart (HOLD_CYCLES=8).
REQ-033 Wrap: rr_ptr=3, req=0101 -> grant_id=0, next grant goes to 2.
REQ-034 Clear collision: clr_req and req=0010 both high in IDLE -> reg_clr=1 the next cycle, no ack, then grant to 1 afterward if req is held.
REQ-035 Abort: clr_req during GRANT's selecting edge -> no reg_en/ack; rr_ptr unchanged.
REQ-036 Async reset in HOLD: rst low mid-cycle -> busy=0 before next edge; HOLD_CYCLES=0 build -> back-to-back grants 2 cycles apart.
